run_length_tx: RTL and testbench

Serial run-length transmitter: accepts (bit value, run length) symbols over a valid/ready handshake and drives a one-bit serial stream that holds each symbol's bit for exactly that many clock cycles. It is the generating end of the consecutive-bit sequence detection path. Its `x` output feeds the detector's serial input, so benches and on-board demos can produce runs of identical bits without hand-writing stimulus. A one-entry holding register lets consecutive symbols stream with no idle gap.

---
 rtl/run_length_tx_if.sv | 24 ++
 rtl/run_length_tx.sv | 109 ++++++++++
 tb/tb_run_length_tx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/run_length_tx_if.sv
// Symbol handshake and serial output bundle for run_length_tx.
// master drives symbols in and observes the stream; slave is the transmitter.
interface run_length_tx_if #(
   parameter int LEN_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic [LEN_W-1:0] in_len;
   logic             x;
   logic             x_active;
   logic             done;
   logic             len_err;

   modport master (
      output in_valid, in_bit, in_len,
      input  in_ready, x, x_active, done, len_err
   );

   modport slave (
      input  in_valid, in_bit, in_len,
      output in_ready, x, x_active, done, len_err
   );
endinterface

// File: rtl/run_length_tx.sv
// Serial run-length transmitter: plays (bit, length) symbols as runs of identical bits,
// with a one-entry holding register so back-to-back symbols stream without a gap.
module run_length_tx #(
   parameter int LEN_W    = 4,
   parameter bit IDLE_BIT = 1'b0
) (
   input logic            clk,
   input logic            reset,
   run_length_tx_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             hold_valid_q, hold_valid_d;
   logic             hold_bit_q, hold_bit_d;
   logic [LEN_W-1:0] hold_len_q, hold_len_d;
   logic             x_q, x_d;
   logic             x_active_q, x_active_d;
   logic             done_q, done_d;
   logic             len_err_q, len_err_d;

   logic             accept;
   logic             take_in;
   logic             slot_free;
   logic             load;
   logic             load_bit;
   logic [LEN_W-1:0] load_len;

   // Zero-length symbols complete the handshake but never become a run.
   assign accept    = bus.in_valid && !hold_valid_q;
   assign take_in   = accept && (bus.in_len != '0);
   assign slot_free = (state_q == IDLE) || (rem_q == LEN_W'(1));
   assign load      = slot_free && (hold_valid_q || take_in);
   assign load_bit  = hold_valid_q ? hold_bit_q : bus.in_bit;
   assign load_len  = hold_valid_q ? hold_len_q : bus.in_len;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         rem_q        <= '0;
         hold_valid_q <= 1'b0;
         x_q          <= IDLE_BIT;
         x_active_q   <= 1'b0;
         done_q       <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         hold_valid_q <= hold_valid_d;
         x_q          <= x_d;
         x_active_q   <= x_active_d;
         done_q       <= done_d;
         len_err_q    <= len_err_d;
      end
   end

   // Held payload is only meaningful while hold_valid_q is set.
   always_ff @(posedge clk) begin
      hold_bit_q <= hold_bit_d;
      hold_len_q <= hold_len_d;
   end

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      hold_valid_d = hold_valid_q;
      hold_bit_d   = hold_bit_q;
      hold_len_d   = hold_len_q;
      if (slot_free) begin
         if (load) begin
            state_d      = SEND;
            rem_d        = load_len;
            hold_valid_d = 1'b0;
         end else begin
            state_d = IDLE;
            rem_d   = '0;
         end
      end else begin
         rem_d = rem_q - LEN_W'(1);
      end
      if (take_in && !slot_free) begin
         hold_valid_d = 1'b1;
         hold_bit_d   = bus.in_bit;
         hold_len_d   = bus.in_len;
      end
   end

   always_comb begin
      x_d        = x_q;
      x_active_d = x_active_q;
      done_d     = 1'b0;
      len_err_d  = accept && (bus.in_len == '0);
      if (load) begin
         x_d        = load_bit;
         x_active_d = 1'b1;
      end else if (slot_free) begin
         x_d        = IDLE_BIT;
         x_active_d = 1'b0;
         done_d     = (state_q == SEND);
      end
   end

   assign bus.in_ready = !hold_valid_q;
   assign bus.x        = x_q;
   assign bus.x_active = x_active_q;
   assign bus.done     = done_q;
   assign bus.len_err  = len_err_q;
endmodule

// File: tb/tb_run_length_tx.sv
// Bench for run_length_tx: directed vector table, hand sequences for long runs and
// mid-symbol reset, then random traffic against a timeline model of the stream.
module tb_run_length_tx;
   localparam int LEN_W = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   run_length_tx_if #(.LEN_W(LEN_W)) bus ();

   run_length_tx #(.LEN_W(LEN_W), .IDLE_BIT(1'b0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       v;
      logic       b;
      logic [3:0] l;
      logic       rdy;
      logic       x;
      logic       act;
      logic       done;
      logic       lerr;
   } vec_t;

   typedef struct {
      int s;
      int len;
      bit b;
   } sym_t;

   vec_t vecs[$];
   sym_t model_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void add(input logic v, input logic b, input logic [3:0] l,
                               input logic rdy, input logic x, input logic act,
                               input logic done, input logic lerr);
      vecs.push_back(vec_t'{v, b, l, rdy, x, act, done, lerr});
   endfunction

   task automatic drive(input logic v, input logic b, input logic [3:0] l);
      bus.in_valid = v;
      bus.in_bit   = b;
      bus.in_len   = l;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic x, input logic act,
                          input logic done, input logic lerr);
      chk({tag, "_x"}, bus.x, x);
      chk({tag, "_act"}, bus.x_active, act);
      chk({tag, "_done"}, bus.done, done);
      chk({tag, "_lerr"}, bus.len_err, lerr);
   endtask

   initial begin
      int t, end_prev, hold_from, hold_until;
      bit prev_act;

      drive(1'b0, 1'b0, 4'd0);
      #12;
      chk("reset_ready", bus.in_ready, 1'b1);
      chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // (1,4) single offer: 4 cycles of 1, then done
      add(1, 1, 4, 1, 1, 1, 0, 0);
      add(0, 0, 0, 1, 1, 1, 0, 0);
      add(0, 0, 0, 1, 1, 1, 0, 0);
      add(0, 0, 0, 1, 1, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      // (1,3),(0,2),(1,1) with in_valid held: 1,1,1,0,0,1
      add(1, 1, 3, 1, 1, 1, 0, 0);
      add(1, 0, 2, 1, 1, 1, 0, 0);
      add(1, 1, 1, 0, 1, 1, 0, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 1, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      // zero-length while idle, then (0,2)
      add(1, 1, 0, 1, 0, 0, 0, 1);
      add(1, 0, 2, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      // zero-length offered during a (0,5) run
      add(1, 0, 5, 1, 0, 1, 0, 0);
      add(1, 1, 0, 1, 0, 1, 0, 1);
      add(0, 0, 0, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].b, vecs[i].l);
         chk($sformatf("vec%0d_ready", i), bus.in_ready, vecs[i].rdy);
         tick();
         chk_out($sformatf("vec%0d", i), vecs[i].x, vecs[i].act, vecs[i].done, vecs[i].lerr);
      end

      // (1,15) then (0,15): 30 gapless cycles
      for (int i = 0; i <= 31; i++) begin
         if (i == 0)      drive(1'b1, 1'b1, 4'd15);
         else if (i == 1) drive(1'b1, 1'b0, 4'd15);
         else             drive(1'b0, 1'b0, 4'd0);
         if (i >= 1 && i <= 16)
            chk($sformatf("max%0d_ready", i), bus.in_ready, (i == 1 || i == 16));
         tick();
         chk_out($sformatf("max%0d", i), (i < 15), (i < 30), (i == 30), 1'b0);
      end

      // reset during cycle 3 of (1,8) with (0,3) held
      drive(1'b1, 1'b1, 4'd8);
      tick();
      drive(1'b1, 1'b0, 4'd3);
      tick();
      drive(1'b0, 1'b0, 4'd0);
      tick();
      chk("rst_pre_x", bus.x, 1'b1);
      chk("rst_pre_ready", bus.in_ready, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_ready", bus.in_ready, 1'b1);
      chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk_out("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 4'd2);
      tick();
      chk_out("rst_run0", 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd0);
      tick();
      chk_out("rst_run1", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_out("rst_run2", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // random traffic against a start-time/end-time model of the stream
      t = 0;
      end_prev = -1;
      hold_from = -1;
      hold_until = -1;
      prev_act = 1'b0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         logic v, b, mrdy, m_x, m_act, m_done, m_lerr;
         logic [3:0] l;
         int s;
         v = ($urandom_range(0, 9) < 6) && (cyc < 460);
         b = 1'($urandom_range(0, 1));
         l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
         drive(v, b, l);
         mrdy = !(t > hold_from && t <= hold_until);
         chk("rnd_ready", bus.in_ready, mrdy);
         m_lerr = v && mrdy && (l == 0);
         if (v && mrdy && l != 0) begin
            s = (end_prev > t) ? end_prev : t;
            model_q.push_back(sym_t'{s, int'(l), b});
            end_prev = s + int'(l);
            if (s > t) begin
               hold_from  = t;
               hold_until = s;
            end
         end
         tick();
         while (model_q.size() > 0 && model_q[0].s + model_q[0].len <= t)
            void'(model_q.pop_front());
         m_x = 1'b0;
         m_act = 1'b0;
         foreach (model_q[k]) begin
            if (model_q[k].s <= t) begin
               m_x = model_q[k].b;
               m_act = 1'b1;
            end
         end
         m_done = prev_act && !m_act;
         prev_act = m_act;
         chk_out("rnd", m_x, m_act, m_done, m_lerr);
         t++;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
